// File: rtl/fp_mul_pipe_if.sv
// Streaming operand/result bundle for the pipelined floating-point multiplier.
// The multiplier uses the slave side; the producer/consumer uses the master side.
interface fp_mul_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 7
);
    localparam int FW = 1 + EXP_W + MAN_W;

    logic          in_valid;
    logic          in_ready;
    logic [FW-1:0] a;
    logic [FW-1:0] b;
    logic          out_valid;
    logic          out_ready;
    logic [FW-1:0] result;
    logic [3:0]    flags;

    modport slave  (input  in_valid, a, b, out_ready,
                    output in_ready, out_valid, result, flags);
    modport master (output in_valid, a, b, out_ready,
                    input  in_ready, out_valid, result, flags);
endinterface

// File: rtl/fp_mul_pipe.sv
// 3-stage pipelined floating-point multiplier (default bfloat16) with RNE rounding,
// IEEE special values, flush-to-zero subnormals and {invalid,overflow,underflow,inexact} flags.
module fp_mul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 7,
    parameter int BIAS  = 2**(EXP_W-1)-1
) (
    input  logic         clk,
    input  logic         rst_n,
    fp_mul_pipe_if.slave io
);
    localparam int FW = 1 + EXP_W + MAN_W;
    localparam int PW = 2 * (MAN_W + 1);
    localparam int XW = EXP_W + 2;
    localparam logic signed [XW-1:0] BIAS_C = XW'(BIAS);
    localparam logic signed [XW-1:0] EMAX_C = XW'((2**EXP_W) - 1);
    localparam logic signed [XW-1:0] ONE_C  = XW'(1);
    localparam logic signed [XW-1:0] ZERO_C = XW'(0);
    localparam logic [FW-1:0] QNAN_C = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    // Operand class as {nan, inf, zero}; zero exponent covers flushed subnormals
    function automatic logic [2:0] classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
        logic e_max;
        logic e_min;
        e_max = &e;
        e_min = ~|e;
        classify = {e_max & (|f), e_max & ~(|f), e_min};
    endfunction

    logic                 en_s;
    logic [2:0]           cls_a_s, cls_b_s;
    logic [PW-1:0]        prod_s;
    logic signed [XW-1:0] exp_s;
    logic [3:0]           spc_s;       // {nan, invalid, inf, zero}

    logic                 v1_r, sign1_r;
    logic signed [XW-1:0] exp1_r;
    logic [PW-1:0]        prod1_r;
    logic [3:0]           spc1_r;

    logic [PW-1:0]        norm_s;
    logic signed [XW-1:0] exp_n_s;

    logic                 v2_r, sign2_r, g2_r, s2_r;
    logic signed [XW-1:0] exp2_r;
    logic [MAN_W:0]       man2_r;
    logic [3:0]           spc2_r;

    logic                 rnd_up_s;
    logic [MAN_W+1:0]     man_rnd_s;
    logic signed [XW-1:0] exp_fin_s;
    logic [MAN_W-1:0]     frac_fin_s;
    logic [FW-1:0]        res_s;
    logic [3:0]           flg_s;

    logic                 out_valid_r;
    logic [FW-1:0]        result_r;
    logic [3:0]           flags_r;

    assign en_s         = ~out_valid_r | io.out_ready;
    assign io.in_ready  = en_s;
    assign io.out_valid = out_valid_r;
    assign io.result    = result_r;
    assign io.flags     = flags_r;

    // Stage 1 logic: classify operands, multiply significands, sum exponents
    always_comb begin
        cls_a_s = classify(io.a[FW-2 -: EXP_W], io.a[MAN_W-1:0]);
        cls_b_s = classify(io.b[FW-2 -: EXP_W], io.b[MAN_W-1:0]);
        prod_s  = PW'({1'b1, io.a[MAN_W-1:0]}) * PW'({1'b1, io.b[MAN_W-1:0]});
        exp_s   = XW'(io.a[FW-2 -: EXP_W]) + XW'(io.b[FW-2 -: EXP_W]) - BIAS_C;
        spc_s[3] = cls_a_s[2] | cls_b_s[2] | (cls_a_s[1] & cls_b_s[0]) | (cls_b_s[1] & cls_a_s[0]);
        spc_s[2] = ~(cls_a_s[2] | cls_b_s[2]) & ((cls_a_s[1] & cls_b_s[0]) | (cls_b_s[1] & cls_a_s[0]));
        spc_s[1] = cls_a_s[1] | cls_b_s[1];
        spc_s[0] = cls_a_s[0] | cls_b_s[0];
    end

    // Stage 1 register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_r    <= 1'b0;
            sign1_r <= 1'b0;
            exp1_r  <= '0;
            prod1_r <= '0;
            spc1_r  <= 4'b0000;
        end else if (en_s) begin
            v1_r    <= io.in_valid;
            sign1_r <= io.a[FW-1] ^ io.b[FW-1];
            exp1_r  <= exp_s;
            prod1_r <= prod_s;
            spc1_r  <= spc_s;
        end
    end

    // Stage 2 logic: product lies in [1,4); a set MSB means shift right and bump exponent
    always_comb begin
        if (prod1_r[PW-1]) begin
            norm_s  = prod1_r;
            exp_n_s = exp1_r + ONE_C;
        end else begin
            norm_s  = {prod1_r[PW-2:0], 1'b0};
            exp_n_s = exp1_r;
        end
    end

    // Stage 2 register: keep significand plus guard and sticky
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_r    <= 1'b0;
            sign2_r <= 1'b0;
            exp2_r  <= '0;
            man2_r  <= '0;
            g2_r    <= 1'b0;
            s2_r    <= 1'b0;
            spc2_r  <= 4'b0000;
        end else if (en_s) begin
            v2_r    <= v1_r;
            sign2_r <= sign1_r;
            exp2_r  <= exp_n_s;
            man2_r  <= norm_s[PW-1 -: MAN_W+1];
            g2_r    <= norm_s[MAN_W];
            s2_r    <= |norm_s[MAN_W-1:0];
            spc2_r  <= spc1_r;
        end
    end

    // Stage 3 logic: round to nearest even, range check, specials, pack
    always_comb begin
        rnd_up_s  = g2_r & (s2_r | man2_r[0]);
        man_rnd_s = {1'b0, man2_r} + {{(MAN_W+1){1'b0}}, rnd_up_s};
        if (man_rnd_s[MAN_W+1]) begin
            exp_fin_s  = exp2_r + ONE_C;
            frac_fin_s = man_rnd_s[MAN_W:1];
        end else begin
            exp_fin_s  = exp2_r;
            frac_fin_s = man_rnd_s[MAN_W-1:0];
        end
        res_s = {FW{1'b0}};
        flg_s = 4'b0000;
        if (spc2_r[3]) begin
            res_s = QNAN_C;
            flg_s = {spc2_r[2], 3'b000};
        end else if (spc2_r[1]) begin
            res_s = {sign2_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flg_s = 4'b0000;
        end else if (spc2_r[0]) begin
            res_s = {sign2_r, {(FW-1){1'b0}}};
            flg_s = 4'b0000;
        end else if (exp_fin_s >= EMAX_C) begin
            res_s = {sign2_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flg_s = 4'b0101;
        end else if (exp_fin_s <= ZERO_C) begin
            res_s = {sign2_r, {(FW-1){1'b0}}};
            flg_s = 4'b0011;
        end else begin
            res_s = {sign2_r, exp_fin_s[EXP_W-1:0], frac_fin_s};
            flg_s = {3'b000, g2_r | s2_r};
        end
    end

    // Output register: payload only reloads when a product arrives, so it holds under stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            result_r    <= '0;
            flags_r     <= 4'b0000;
        end else if (en_s) begin
            out_valid_r <= v2_r;
            if (v2_r) begin
                result_r <= res_s;
                flags_r  <= flg_s;
            end
        end
    end
endmodule
